// File: rtl/mux_16_to_1_pkg.sv
// Shared constants for the 16:1 registered lane selector and its 4:1 tree nodes.
package mux_16_to_1_pkg;
  localparam int NUM_LANES  = 16;
  localparam int SEL_W      = 4;
  localparam int LEAF_FANIN = 4;
  localparam int NUM_LEAVES = NUM_LANES / LEAF_FANIN;
  // Per-bit reset value; registers replicate it to their own width.
  localparam logic RST_BIT  = 1'b0;
endpackage

// File: rtl/mux_4to1.sv
// Combinational 4:1 selector over DATA_W-bit lanes packed LSB-first in one port.
module mux_4to1 #(
  parameter int DATA_W = 1
) (
  input  logic [4*DATA_W-1:0] in,
  input  logic [1:0]          sel,
  output logic [DATA_W-1:0]   out
);
  // A case per lane keeps unselected lanes out of the result entirely.
  always_comb begin
    out = '0;
    case (sel)
      2'd0: out = in[0*DATA_W +: DATA_W];
      2'd1: out = in[1*DATA_W +: DATA_W];
      2'd2: out = in[2*DATA_W +: DATA_W];
      2'd3: out = in[3*DATA_W +: DATA_W];
      default: out = '0;
    endcase
  end
endmodule

// File: rtl/mux_16_to_1.sv
// Registered 16:1 lane selector: four 4:1 leaves, one 4:1 root, output register.
// Define MUX_16_TO_1_IN_REG_EN to register in/sel ahead of the tree (2-cycle latency).
module mux_16_to_1
  import mux_16_to_1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_LANES*DATA_W-1:0] in,
  input  logic [SEL_W-1:0]            sel,
  output logic [DATA_W-1:0]           out
);
  logic [NUM_LANES*DATA_W-1:0]        tree_in;
  logic [SEL_W-1:0]                   tree_sel;
  logic [NUM_LEAVES-1:0][DATA_W-1:0]  leaf;
  logic [DATA_W-1:0]                  root;

`ifdef MUX_16_TO_1_IN_REG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree_in  <= {(NUM_LANES*DATA_W){RST_BIT}};
      tree_sel <= {SEL_W{RST_BIT}};
    end else begin
      tree_in  <= in;
      tree_sel <= sel;
    end
  end
`else
  assign tree_in  = in;
  assign tree_sel = sel;
`endif

  for (genvar j = 0; j < NUM_LEAVES; j++) begin : g_leaf
    mux_4to1 #(.DATA_W(DATA_W)) u_leaf (
      .in  (tree_in[j*LEAF_FANIN*DATA_W +: LEAF_FANIN*DATA_W]),
      .sel (tree_sel[1:0]),
      .out (leaf[j])
    );
  end

  mux_4to1 #(.DATA_W(DATA_W)) u_root (
    .in  (leaf),
    .sel (tree_sel[3:2]),
    .out (root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= {DATA_W{RST_BIT}};
    else        out <= root;
  end
endmodule

// File: tb/tb_mux_16_to_1.sv
// Self-checking bench: 1-bit and 8-bit instances against a delayed lane-select model.
module tb_mux_16_to_1;
`ifdef MUX_16_TO_1_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  in1;
  logic [3:0]   sel1;
  logic [0:0]   out1;
  logic [127:0] in8;
  logic [3:0]   sel8;
  logic [7:0]   out8;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  mux_16_to_1 #(.DATA_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .in(in1), .sel(sel1), .out(out1));
  mux_16_to_1 #(.DATA_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .out(out8));

  function automatic logic [0:0] lane1(logic [15:0] v, logic [3:0] s);
    logic [15:0] t;
    t = v >> s;
    return t[0];
  endfunction

  function automatic logic [7:0] lane8(logic [127:0] v, logic [3:0] s);
    logic [127:0] t;
    t = v >> (8 * int'(s));
    return t[7:0];
  endfunction

  // Model: selected lane delayed by LAT edges; reset empties the pipe to zeros.
  logic [0:0] e1 [LAT];
  logic [7:0] e8 [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        e1[i] <= '0;
        e8[i] <= '0;
      end
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        e1[i] <= e1[i-1];
        e8[i] <= e8[i-1];
      end
`ifdef MUX_16_TO_1_IN_REG_EN
      e1[0] <= lane1(in1, sel1);
      e8[0] <= lane8(in8, sel8);
`else
      e1[0] <= lane1(in1, sel1);
      e8[0] <= lane8(in8, sel8);
`endif
    end
  end

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("model1", {7'd0, out1}, {7'd0, e1[LAT-1]});
      check("model8", out8, e8[LAT-1]);
    end
  end

  task automatic drive(logic [15:0] i1, logic [3:0] s1);
    @(negedge clk);
    in1  = i1;
    sel1 = s1;
  endtask

  task automatic wait_lat();
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst1", {7'd0, out1}, 8'h00);
    check("async_rst8", out8, 8'h00);
    rst_n = 1'b1;
  endtask

  logic [15:0] sweep_exp;
  logic [15:0] pat;

  initial begin
    rst_n = 1'b1;
    in1 = 16'hFFFF; sel1 = 4'hF;
    in8 = '1;       sel8 = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out1", {7'd0, out1}, 8'h00);
    check("rst_out8", out8, 8'h00);
    repeat (2) @(posedge clk);
    #1 check("rst_held", {7'd0, out1}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    wait_lat();
    check("rel_out1", {7'd0, out1}, 8'h01);
    check("rel_out8", out8, 8'hFF);
    // Asynchronous assertion between edges while output is 1.
    @(negedge clk);
    rst_pulse();
    wait_lat();
    check("resume", {7'd0, out1}, 8'h01);
    chk_en = 1'b1;

    // Fixed sel=0, in stepped 0..15: out reads in[0].
    for (int i = 0; i < 16; i++) begin
      drive(16'(i), 4'd0);
      wait_lat();
      check("step", {7'd0, out1}, {7'd0, 1'(i & 1)});
    end

    // Walking one, selected and neighbour lanes; reset pulse mid-run.
    for (int k = 0; k < 16; k++) begin
      pat = 16'h0001 << k;
      drive(pat, 4'(k));
      if (k == 7) rst_pulse();
      wait_lat();
      check("walk_hit", {7'd0, out1}, 8'h01);
      drive(pat, 4'((k + 1) % 16));
      wait_lat();
      check("walk_miss", {7'd0, out1}, 8'h00);
    end

    // Full sweep over 16'hA5C3.
    sweep_exp = 16'b1010_0101_1100_0011;
    for (int s = 0; s < 16; s++) begin
      drive(16'hA5C3, 4'(s));
      wait_lat();
      check("sweep", {7'd0, out1}, {7'd0, sweep_exp[s]});
    end

    // 8-bit lanes 8'h10+k: sel 0 -> 9 shows 8'h19 after exactly LAT edges.
    @(negedge clk);
    for (int k = 0; k < 16; k++) in8[k*8 +: 8] = 8'(8'h10 + k);
    sel8 = 4'd0;
    wait_lat();
    check("w8_sel0", out8, 8'h10);
    @(negedge clk) sel8 = 4'd9;
    repeat (LAT - 1) @(posedge clk);
    #1 check("w8_early", out8, 8'h10);
    @(posedge clk);
    #1 check("w8_sel9", out8, 8'h19);

    // Randomized streaming, checked every cycle by the model compare.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in1  = 16'($urandom);
      sel1 = 4'($urandom_range(0, 15));
      for (int w = 0; w < 4; w++) in8[w*32 +: 32] = $urandom;
      sel8 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) rst_pulse();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
